// File: rtl/calc_pkg.sv
// Shared types for the calc controller: state codes, datapath mux/ALU codes,
// register-file map and the decoded control word.
package calc_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLR    = 3'd1;
    localparam logic [2:0] ST_LOAD_A = 3'd2;
    localparam logic [2:0] ST_LOAD_B = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_SHOW   = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
`ifdef CALC_CTRL_CLR_EN
        S_CLR    = ST_CLR,
`endif
        S_LOAD_A = ST_LOAD_A,
        S_LOAD_B = ST_LOAD_B,
        S_EXEC   = ST_EXEC,
        S_SHOW   = ST_SHOW,
        S_DONE   = ST_DONE
    } state_e;

    // Datapath input-mux select codes.
    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_ZERO = 2'b01,
        SEL_IN2  = 2'b10,
        SEL_IN1  = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    // Register map: operands in R0/R1, result in R2.
    typedef enum logic [1:0] {
        R0 = 2'd0,
        R1 = 2'd1,
        R2 = 2'd2
    } reg_e;

    typedef struct packed {
        sel_e    s1;
        logic    we;
        reg_e    wa;
        logic    rea;
        reg_e    raa;
        logic    reb;
        reg_e    rab;
        alu_op_e c;
        logic    s2;
        logic    done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        s1:   SEL_ZERO,
        we:   1'b0,
        wa:   R0,
        rea:  1'b0,
        raa:  R0,
        reb:  1'b0,
        rab:  R0,
        c:    OP_ADD,
        s2:   1'b0,
        done: 1'b0
    };

endpackage

// File: rtl/calc_ctrl_if.sv
// Control bus between calc_ctrl and its datapath; the master modport is the
// controller's view (go/op in, datapath controls out).
interface calc_ctrl_if;

    logic       go;
    logic [1:0] op;
    logic [1:0] s1;
    logic       we;
    logic [1:0] wa;
    logic       rea;
    logic       reb;
    logic [1:0] raa;
    logic [1:0] rab;
    logic [1:0] c;
    logic       s2;
    logic       busy;
    logic       done;

    modport master (
        input  go, op,
        output s1, we, wa, rea, reb, raa, rab, c, s2, busy, done
    );

    modport slave (
        output go, op,
        input  s1, we, wa, rea, reb, raa, rab, c, s2, busy, done
    );

endinterface

// File: rtl/calc_ctrl.sv
// Moore controller sequencing load A, load B, execute, show and done on a
// register-file/ALU datapath. Optional macro CALC_CTRL_CLR_EN adds a CLR state.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned OUT_CYC = 2  // result display cycles, 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    calc_ctrl_if.master bus
);

    localparam logic [3:0] SHOW_LAST = 4'(OUT_CYC - 1);

    state_e     state;
    state_e     state_nxt;
    alu_op_e    op_q;
    logic [3:0] show_cnt;
    ctrl_t      ctl;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.go) begin
`ifdef CALC_CTRL_CLR_EN
                    state_nxt = S_CLR;
`else
                    state_nxt = S_LOAD_A;
`endif
                end
            end
`ifdef CALC_CTRL_CLR_EN
            S_CLR:    state_nxt = S_LOAD_A;
`endif
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_SHOW;
            S_SHOW: begin
                if (show_cnt == SHOW_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= OP_ADD;
            show_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.go) begin
                op_q <= alu_op_e'(bus.op);
            end
            if (state == S_SHOW && show_cnt != SHOW_LAST) begin
                show_cnt <= show_cnt + 4'd1;
            end else begin
                show_cnt <= '0;
            end
        end
    end

    // Outputs decode from the state register alone.
    always_comb begin
        ctl = CTRL_IDLE;
        case (state)
`ifdef CALC_CTRL_CLR_EN
            S_CLR: begin
                ctl.s1 = SEL_ZERO;
                ctl.we = 1'b1;
                ctl.wa = R2;
            end
`endif
            S_LOAD_A: begin
                ctl.s1 = SEL_IN1;
                ctl.we = 1'b1;
                ctl.wa = R0;
            end
            S_LOAD_B: begin
                ctl.s1 = SEL_IN2;
                ctl.we = 1'b1;
                ctl.wa = R1;
            end
            S_EXEC: begin
                ctl.rea = 1'b1;
                ctl.raa = R0;
                ctl.reb = 1'b1;
                ctl.rab = R1;
                ctl.c   = op_q;
                ctl.s1  = SEL_ALU;
                ctl.we  = 1'b1;
                ctl.wa  = R2;
            end
            S_SHOW: begin
                // R2 + 0 through the ALU puts the stored result on out.
                ctl.rea = 1'b1;
                ctl.raa = R2;
                ctl.c   = OP_ADD;
                ctl.s2  = 1'b1;
            end
            S_DONE: begin
                ctl.done = 1'b1;
            end
            default: ctl = CTRL_IDLE;
        endcase
    end

    assign bus.s1   = ctl.s1;
    assign bus.we   = ctl.we;
    assign bus.wa   = ctl.wa;
    assign bus.rea  = ctl.rea;
    assign bus.raa  = ctl.raa;
    assign bus.reb  = ctl.reb;
    assign bus.rab  = ctl.rab;
    assign bus.c    = ctl.c;
    assign bus.s2   = ctl.s2;
    assign bus.done = ctl.done;
    assign bus.busy = (state != S_IDLE);

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl driving a 3-bit register-file/ALU datapath model;
// expected values are hand-computed per vector.
module tb_calc_ctrl;

    localparam int OUT_CYC = 2;
`ifdef CALC_CTRL_CLR_EN
    localparam int CLR_CYC = 1;
`else
    localparam int CLR_CYC = 0;
`endif

    localparam int T_IDLE   = 0;
    localparam int T_CLR    = 1;
    localparam int T_LOAD_A = 2;
    localparam int T_LOAD_B = 3;
    localparam int T_EXEC   = 4;
    localparam int T_SHOW   = 5;
    localparam int T_DONE   = 6;

    typedef struct {
        string      name;
        logic [2:0] in1;
        logic [2:0] in2;
        logic [1:0] op;
        logic [1:0] op_alt;
        bit         swap;
        bit         go_exec;
        logic [2:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] in1;
    logic [2:0] in2;
    int         checks;
    int         errors;
    int         done_cnt;

    calc_ctrl_if bus ();

    calc_ctrl #(.OUT_CYC(OUT_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: 3-bit register file, input mux, ALU, output mux.
    logic [2:0] rf [4];
    logic [2:0] wdata;
    logic [2:0] a_val;
    logic [2:0] b_val;
    logic [2:0] alu;
    logic [2:0] out;

    always_comb begin
        a_val = bus.rea ? rf[bus.raa] : 3'd0;
        b_val = bus.reb ? rf[bus.rab] : 3'd0;
        case (bus.c)
            2'b00:   alu = a_val + b_val;
            2'b01:   alu = a_val - b_val;
            2'b10:   alu = a_val & b_val;
            default: alu = a_val ^ b_val;
        endcase
        case (bus.s1)
            2'b11:   wdata = in1;
            2'b10:   wdata = in2;
            2'b01:   wdata = 3'd0;
            default: wdata = alu;
        endcase
        out = bus.s2 ? alu : 3'd0;
    end

    always @(posedge clk) begin
        if (bus.we) rf[bus.wa] <= wdata;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pack(input logic [1:0] s1, input logic we, input logic [1:0] wa,
                                         input logic rea, input logic [1:0] raa, input logic reb,
                                         input logic [1:0] rab, input logic [1:0] c, input logic s2,
                                         input logic busy, input logic done);
        return {s1, we, wa, rea, raa, reb, rab, c, s2, busy, done};
    endfunction

    task automatic check_state(input string name, input int st, input logic [1:0] opv);
        logic [15:0] act;
        logic [15:0] exp;
        logic [15:0] mask;
        act = pack(bus.s1, bus.we, bus.wa, bus.rea, bus.raa, bus.reb, bus.rab,
                   bus.c, bus.s2, bus.busy, bus.done);
        case (st)
            T_IDLE: begin
                exp  = pack(2'b01, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
                mask = 16'hFFFF;
            end
            T_CLR: begin
                exp  = pack(2'b01, 1, 2'b10, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0);
                mask = pack(2'b11, 1, 2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 1);
            end
            T_LOAD_A: begin
                exp  = pack(2'b11, 1, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0);
                mask = pack(2'b11, 1, 2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 1);
            end
            T_LOAD_B: begin
                exp  = pack(2'b10, 1, 2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0);
                mask = pack(2'b11, 1, 2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 1);
            end
            T_EXEC: begin
                exp  = pack(2'b00, 1, 2'b10, 1, 2'b00, 1, 2'b01, opv, 0, 1, 0);
                mask = pack(2'b11, 1, 2'b11, 1, 2'b11, 1, 2'b11, 2'b11, 0, 1, 1);
            end
            T_SHOW: begin
                exp  = pack(2'b00, 0, 2'b00, 1, 2'b10, 0, 2'b00, 2'b00, 1, 1, 0);
                mask = pack(2'b00, 1, 2'b00, 1, 2'b11, 1, 2'b00, 2'b11, 1, 1, 1);
            end
            default: begin
                exp  = pack(2'b00, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 1);
                mask = pack(2'b00, 1, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 1);
            end
        endcase
        check(name, act & mask, exp & mask);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // go sampled at edge k; returns in the first cycle after that edge.
    task automatic start(input logic [2:0] a, input logic [2:0] b, input logic [1:0] opv);
        in1 = a;
        in2 = b;
        bus.op = opv;
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        d0 = done_cnt;
        start(v.in1, v.in2, v.op);
        if (CLR_CYC == 1) begin
            check_state({v.name, "/clr"}, T_CLR, v.op);
            step();
        end
        check_state({v.name, "/load_a"}, T_LOAD_A, v.op);
        step();
        check_state({v.name, "/load_b"}, T_LOAD_B, v.op);
        if (v.swap) bus.op = v.op_alt;
        step();
        check_state({v.name, "/exec"}, T_EXEC, v.op);
        if (v.go_exec) bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        for (int i = 0; i < OUT_CYC; i++) begin
            check_state({v.name, "/show"}, T_SHOW, v.op);
            check({v.name, "/out"}, {13'd0, out}, {13'd0, v.exp});
            step();
        end
        check_state({v.name, "/done"}, T_DONE, v.op);
        step();
        check_state({v.name, "/idle"}, T_IDLE, v.op);
        step();
        check_state({v.name, "/no_restart"}, T_IDLE, v.op);
        check({v.name, "/done_count"}, 16'(done_cnt - d0), 16'd1);
    endtask

    vec_t vecs [6];

    initial begin
        int d0;
        vecs[0] = '{"add_3_2",   3'd3, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 3'd5};
        vecs[1] = '{"sub_wrap",  3'd2, 3'd3, 2'b01, 2'b01, 1'b0, 1'b0, 3'd7};
        vecs[2] = '{"xor_swap",  3'd5, 3'd3, 2'b11, 2'b10, 1'b1, 1'b0, 3'd6};
        vecs[3] = '{"and_6_3",   3'd6, 3'd3, 2'b10, 2'b10, 1'b0, 1'b0, 3'd2};
        vecs[4] = '{"add_wrap",  3'd7, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 3'd6};
        vecs[5] = '{"go_exec",   3'd4, 3'd6, 2'b11, 2'b11, 1'b0, 1'b1, 3'd2};

        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        bus.go   = 1'b0;
        bus.op   = 2'b00;
        in1      = 3'd0;
        in2      = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", T_IDLE, 2'b00);
        rst_n = 1'b1;
        step();
        check_state("post_reset", T_IDLE, 2'b00);

        foreach (vecs[i]) run_vec(vecs[i]);

        // go held high through DONE restarts only after one IDLE cycle.
        d0 = done_cnt;
        in1 = 3'd1;
        in2 = 3'd1;
        bus.op = 2'b00;
        bus.go = 1'b1;
        repeat (4 + OUT_CYC + CLR_CYC) step();
        check_state("held/done", T_DONE, 2'b00);
        step();
        check_state("held/idle", T_IDLE, 2'b00);
        step();
        check_state("held/restart", (CLR_CYC == 1) ? T_CLR : T_LOAD_A, 2'b00);
        bus.go = 1'b0;
        repeat (3 + OUT_CYC + CLR_CYC) step();
        check_state("held/done2", T_DONE, 2'b00);
        step();
        check("held/done_count", 16'(done_cnt - d0), 16'd2);

        // Reset during EXEC aborts without a done pulse.
        d0 = done_cnt;
        start(3'd3, 3'd1, 2'b01);
        repeat (2 + CLR_CYC) step();
        check_state("abort/exec", T_EXEC, 2'b01);
        #2 rst_n = 1'b0;
        #1 check_state("abort/reset_now", T_IDLE, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (OUT_CYC + 3) step();
        check_state("abort/idle", T_IDLE, 2'b00);
        check("abort/no_done", 16'(done_cnt - d0), 16'd0);

        run_vec('{"after_abort", 3'd3, 3'd1, 2'b01, 2'b01, 1'b0, 1'b0, 3'd2});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
